// File: rtl/pwm_dac_if.sv
// Bundles the sample/control inputs and the PWM/observability outputs of the
// pwm_dac output stage.
//
// Handshake semantics: there is no valid/ready pair. The upstream side holds
// sample_in and mode continuously. The stage reads them only in the period
// boundary cycle, and announces that read with a one-cycle sample_tick.
// sample_tick is asserted in the cycle the new duty becomes active. en is a
// level-sensitive count enable, not a handshake.
interface pwm_dac_if #(
  parameter int o  = 16,
  parameter int PW = 8
);
  // Upstream controls
  logic              en;
  logic              mode;
  logic [o-1:0]      sample_in;

  // Stage outputs
  logic              pwm_out;
  logic              sample_tick;
  logic [PW-1:0]     duty;

  // Internal state mirrors, for checkers and debug
  logic [PW-1:0]     dbg_cnt;
  logic [o-PW-1:0]   dbg_err;

  // Upstream / bench side
  modport master (
    output en, mode, sample_in,
    input  pwm_out, sample_tick, duty, dbg_cnt, dbg_err
  );

  // PWM stage side
  modport slave (
    input  en, mode, sample_in,
    output pwm_out, sample_tick, duty, dbg_cnt, dbg_err
  );
endinterface

// File: rtl/pwm_dac.sv
// PWM output stage. It converts an o-bit unsigned sample into a single-bit PWM
// stream with 2^PW cycles per period. An optional first-order error-feedback
// path carries the truncated sample LSBs into later periods. A one-cycle tick
// marks each period in which a new duty value takes effect.
//
// The parameters must satisfy 1 <= PW < o.
module pwm_dac #(
  parameter int o  = 16,
  parameter int PW = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  pwm_dac_if.slave   bus
);

  // Width of the error accumulator, which holds the bits truncated below the duty.
  localparam int EW = o - PW;

  // Period counter, active duty, error accumulator and registered outputs
  logic [PW-1:0] cnt;
  logic [PW-1:0] duty_q;
  logic [EW-1:0] err_q;
  logic          pwm_q;
  logic          tick_q;

  // Boundary evaluation terms
  logic          boundary;
  logic [o:0]    sum;
  logic          sat;
  logic [PW-1:0] next_duty;
  logic [EW-1:0] next_err;

  // Detect the boundary and compute the duty and error to latch there.
  // With mode=0 the error term is zero, so the sum cannot overflow and the
  // sample is plainly truncated. The error is also cleared, which keeps a
  // mode change clean at the next latch.
  always_comb begin
    boundary  = 1'b0;
    sum       = '0;
    sat       = 1'b0;
    next_duty = '0;
    next_err  = '0;

    boundary = bus.en && (cnt == {PW{1'b1}});
    sum      = {1'b0, bus.sample_in}
             + (bus.mode ? {{(o + 1 - EW){1'b0}}, err_q} : {(o + 1){1'b0}});
    sat      = sum[o];

    if (sat) begin
      // Saturate instead of wrapping to a small duty
      next_duty = {PW{1'b1}};
      next_err  = '0;
    end else begin
      next_duty = sum[o-1 -: PW];
      next_err  = bus.mode ? sum[EW-1:0] : {EW{1'b0}};
    end
  end

  // Counter, duty/error latch and registered PWM/tick outputs. With en low,
  // all state freezes so the current period is stretched, not restarted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      duty_q <= '0;
      err_q  <= '0;
      pwm_q  <= 1'b0;
      tick_q <= 1'b0;
    end else if (bus.en) begin
      // The compare uses the pre-edge cnt and duty, so the PWM output
      // lags the counter by one cycle.
      pwm_q  <= (cnt < duty_q);
      tick_q <= boundary;
      cnt    <= cnt + PW'(1);
      if (boundary) begin
        duty_q <= next_duty;
        err_q  <= next_err;
      end
    end else begin
      pwm_q  <= 1'b0;
      tick_q <= 1'b0;
    end
  end

  // Outputs and state mirrors
  assign bus.pwm_out     = pwm_q;
  assign bus.sample_tick = tick_q;
  assign bus.duty        = duty_q;
  assign bus.dbg_cnt     = cnt;
  assign bus.dbg_err     = err_q;

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac. It uses the parameters o=16 and PW=8, so there
// are 256 cycles per period.
module tb_pwm_dac;

  localparam int O  = 16;
  localparam int PW = 8;
  localparam int PERIOD = 256;

  logic clk;
  logic rst_n;

  int pass_cnt;
  int total_cnt;

  pwm_dac_if #(.o(O), .PW(PW)) bus ();

  pwm_dac #(.o(O), .PW(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one full period of steps; count high cycles and note the first tick
  task automatic run_period(output int highs, output int tick_at);
    highs   = 0;
    tick_at = -1;
    for (int i = 1; i <= PERIOD; i++) begin
      step();
      if (bus.pwm_out === 1'b1) highs++;
      if (bus.sample_tick === 1'b1 && tick_at < 0) tick_at = i;
    end
  endtask

  // Count steps until sample_tick, bounded
  task automatic wait_tick(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (bus.sample_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    int highs;
    int tick_at;
    rst_n         = 1'b0;
    bus.en        = 1'b1;
    bus.mode      = 1'b0;
    bus.sample_in = 16'h8000;
    step();
    step();
    total_cnt++;
    if ({bus.pwm_out, bus.sample_tick, bus.duty, bus.dbg_cnt, bus.dbg_err} !== 26'd0)
      $display("FAIL reset_state: got pwm=%b tick=%b duty=%h cnt=%h err=%h, want all 0",
               bus.pwm_out, bus.sample_tick, bus.duty, bus.dbg_cnt, bus.dbg_err);
    else pass_cnt++;
    rst_n = 1'b1;
    wait_tick(300, n);
    total_cnt++;
    if (n !== 256) $display("FAIL first_tick_latency: got %0d want 256", n);
    else pass_cnt++;
    total_cnt++;
    if (bus.duty !== 8'h80) $display("FAIL first_duty: got %h want 80", bus.duty);
    else pass_cnt++;
    run_period(highs, tick_at);
    total_cnt++;
    if (highs !== 128) $display("FAIL half_duty_highs: got %0d want 128", highs);
    else pass_cnt++;
    total_cnt++;
    if (tick_at !== 256) $display("FAIL tick_period: got %0d want 256", tick_at);
    else pass_cnt++;
  endtask

  task automatic test_truncation();
    int highs;
    int tick_at;
    bus.mode      = 1'b0;
    bus.sample_in = 16'h0000;
    run_period(highs, tick_at);          // latches duty 0
    total_cnt++;
    if (bus.duty !== 8'h00 || bus.dbg_err !== 8'h00)
      $display("FAIL trunc_zero_latch: got duty=%h err=%h want 00/00", bus.duty, bus.dbg_err);
    else pass_cnt++;
    bus.sample_in = 16'hFFFF;
    run_period(highs, tick_at);          // runs with duty 0, latches FF
    total_cnt++;
    if (highs !== 0) $display("FAIL zero_duty_highs: got %0d want 0", highs);
    else pass_cnt++;
    total_cnt++;
    if (bus.duty !== 8'hFF || bus.dbg_err !== 8'h00)
      $display("FAIL trunc_full_latch: got duty=%h err=%h want FF/00", bus.duty, bus.dbg_err);
    else pass_cnt++;
    run_period(highs, tick_at);
    total_cnt++;
    if (highs !== 255) $display("FAIL full_duty_highs: got %0d want 255", highs);
    else pass_cnt++;
  endtask

  task automatic test_dither();
    int highs;
    int tick_at;
    int total_highs;
    logic [7:0] exp_duty[4];
    logic [7:0] exp_err[4];
    exp_duty[0] = 8'h01; exp_err[0] = 8'h00;
    exp_duty[1] = 8'h00; exp_err[1] = 8'h80;
    exp_duty[2] = 8'h01; exp_err[2] = 8'h00;
    exp_duty[3] = 8'h00; exp_err[3] = 8'h80;
    bus.mode      = 1'b1;
    bus.sample_in = 16'h0080;
    run_period(highs, tick_at);          // err was 0 -> duty 0, err 80
    total_cnt++;
    if (bus.duty !== 8'h00 || bus.dbg_err !== 8'h80)
      $display("FAIL dither_latch0: got duty=%h err=%h want 00/80", bus.duty, bus.dbg_err);
    else pass_cnt++;
    total_highs = 0;
    for (int p = 0; p < 4; p++) begin
      run_period(highs, tick_at);
      total_highs += highs;
      total_cnt++;
      if (bus.duty !== exp_duty[p] || bus.dbg_err !== exp_err[p])
        $display("FAIL dither_latch%0d: got duty=%h err=%h want %h/%h",
                 p + 1, bus.duty, bus.dbg_err, exp_duty[p], exp_err[p]);
      else pass_cnt++;
    end
    total_cnt++;
    if (total_highs !== 2) $display("FAIL dither_avg_highs: got %0d want 2", total_highs);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int highs;
    int tick_at;
    bus.mode      = 1'b0;
    bus.sample_in = 16'h0000;
    run_period(highs, tick_at);          // mode 0 clears err
    total_cnt++;
    if (bus.dbg_err !== 8'h00) $display("FAIL mode0_clears_err: got %h want 00", bus.dbg_err);
    else pass_cnt++;
    bus.mode      = 1'b1;
    bus.sample_in = 16'h00FF;
    run_period(highs, tick_at);
    total_cnt++;
    if (bus.duty !== 8'h00 || bus.dbg_err !== 8'hFF)
      $display("FAIL sat_pre_latch: got duty=%h err=%h want 00/FF", bus.duty, bus.dbg_err);
    else pass_cnt++;
    bus.sample_in = 16'hFFFF;
    run_period(highs, tick_at);          // FFFF + FF overflows
    total_cnt++;
    if (bus.duty !== 8'hFF || bus.dbg_err !== 8'h00)
      $display("FAIL sat_latch: got duty=%h err=%h want FF/00", bus.duty, bus.dbg_err);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    int highs;
    int tick_at;
    int n;
    int bad_cnt;
    int bad_pwm;
    int bad_tick;
    bus.mode      = 1'b0;
    bus.sample_in = 16'h8000;
    run_period(highs, tick_at);          // duty 80, cnt 0 now
    for (int i = 0; i < 100; i++) step();
    total_cnt++;
    if (bus.dbg_cnt !== 8'd100 || bus.pwm_out !== 1'b1)
      $display("FAIL pause_setup: got cnt=%0d pwm=%b want 100/1", bus.dbg_cnt, bus.pwm_out);
    else pass_cnt++;
    bus.en   = 1'b0;
    bad_cnt  = 0;
    bad_pwm  = 0;
    bad_tick = 0;
    for (int i = 0; i < 50; i++) begin
      // Changes to the sample while paused must not matter
      bus.sample_in = 16'h1234;
      step();
      if (bus.dbg_cnt !== 8'd100) bad_cnt++;
      if (bus.pwm_out !== 1'b0) bad_pwm++;
      if (bus.sample_tick !== 1'b0) bad_tick++;
    end
    total_cnt++;
    if (bad_cnt !== 0) $display("FAIL pause_cnt_hold: got %0d bad cycles want 0", bad_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bad_pwm !== 0) $display("FAIL pause_pwm_low: got %0d bad cycles want 0", bad_pwm);
    else pass_cnt++;
    total_cnt++;
    if (bad_tick !== 0) $display("FAIL pause_no_tick: got %0d ticks want 0", bad_tick);
    else pass_cnt++;
    bus.sample_in = 16'h8000;
    bus.en        = 1'b1;
    wait_tick(300, n);
    total_cnt++;
    if (n !== 156) $display("FAIL resume_tick: got %0d want 156", n);
    else pass_cnt++;
    total_cnt++;
    if (bus.duty !== 8'h80) $display("FAIL resume_duty: got %h want 80", bus.duty);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int n;
    int highs;
    int tick_at;
    for (int i = 0; i < 40; i++) step();
    total_cnt++;
    if (bus.dbg_cnt !== 8'd40 || bus.duty !== 8'h80 || bus.pwm_out !== 1'b1)
      $display("FAIL areset_setup: got cnt=%0d duty=%h pwm=%b want 40/80/1",
               bus.dbg_cnt, bus.duty, bus.pwm_out);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.pwm_out, bus.sample_tick, bus.duty, bus.dbg_cnt, bus.dbg_err} !== 26'd0)
      $display("FAIL areset_immediate: got pwm=%b tick=%b duty=%h cnt=%h err=%h want all 0",
               bus.pwm_out, bus.sample_tick, bus.duty, bus.dbg_cnt, bus.dbg_err);
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    wait_tick(300, n);
    total_cnt++;
    if (n !== 256 || bus.duty !== 8'h80)
      $display("FAIL areset_relatch: got tick at %0d duty=%h want 256/80", n, bus.duty);
    else pass_cnt++;
    run_period(highs, tick_at);
    total_cnt++;
    if (highs !== 128 || tick_at !== 256)
      $display("FAIL areset_period: got highs=%0d tick at %0d want 128/256", highs, tick_at);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt      = 0;
    total_cnt     = 0;
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.mode      = 1'b0;
    bus.sample_in = '0;
    test_reset();
    test_truncation();
    test_dither();
    test_saturation();
    test_pause();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
